a2d_scan_seq: RTL and testbench
===============================

Name: a2d_scan_seq

Overview:
- Channel-scan sequencer that sits directly upstream and downstream of the A2D SPI interface (A2D_intf).
- Drives the interface's strt_cnv/chnnl and consumes its res/cnv_cmplt.
- Walks the enabled channels of the ADC128S, averages 2^AVG_LOG2 conversions per channel, and un-inverts the ADC result (interface res is the bitwise complement of the analog value).
- Holds one 12-bit averaged reading per channel for the rest of the design to read.

Parameters:
- AVG_LOG2, 2, log2 of conversions averaged per channel (legal 0..4).
- GAP_CYCLES, 10, idle clocks between cnv_cmplt and the next strt_cnv (legal 1..255).
- TIMEOUT_CYC, 1023, watchdog limit in clocks (used only with A2D_SEQ_TIMEOUT_EN).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- scan_go, input, 1, one-cycle request to start a scan.
- cont, input, 1, continuous mode; re-scan automatically while high.
- ch_mask, input, 8, channel enable; bit n = channel n. Sampled at scan start.
- strt_cnv, output, 1, to A2D_intf; one-cycle start pulse.
- chnnl, output, 3, to A2D_intf; channel under conversion.
- cnv_cmplt, input, 1, from A2D_intf.
- res, input, 12, from A2D_intf (complemented data).
- rd_chnl, input, 3, read select.
- rd_data, output, 12, averaged value of rd_chnl; registered, 1-cycle latency.
- rd_valid, output, 1, registered valid bit of rd_chnl.
- busy, output, 1, high from the accepted scan_go until scan_done.
- scan_done, output, 1, one-cycle pulse at the end of each scan.
- timeout_err, output, 1, sticky watchdog flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n low): all outputs 0, chnnl=0, result file and valid bits 0, FSM in IDLE. Reset mid-conversion aborts with no further strt_cnv.
- FSM states: IDLE, NEXT, START, WAIT, GAP, DONE.
- IDLE: scan_go=1 latches ch_mask into mask_q, clears all valid bits, sets busy, goes to NEXT. scan_go while busy is ignored.
- NEXT: selects the lowest set bit of mask_q at or above the current index.
  - If a channel is found: chnnl=that channel, accumulator=0, sample count=0, go to START.
  - If none remain: go to DONE.
- START: strt_cnv=1 for exactly one clock; go to WAIT. chnnl stays stable from START until that channel's last conversion completes.
- WAIT: completion is the rising edge of cnv_cmplt (compare against its registered previous value), so either pulse or level handshake is accepted.
  - On completion: acc += ~res. Accumulator width is 12+AVG_LOG2 bits and never overflows.
  - Go to GAP.
- GAP: count GAP_CYCLES clocks, then:
  - If samples < 2^AVG_LOG2: go to START.
  - Otherwise: write acc >> AVG_LOG2 (truncating) to file[chnnl], set valid[chnnl], advance the index, go to NEXT.
- DONE: pulse scan_done for 1 clock.
  - If cont=1: re-latch ch_mask and go to NEXT; busy stays high and valid bits are not cleared.
  - Otherwise: busy=0, go to IDLE.
- ch_mask=0 on scan_go: no strt_cnv; scan_done pulses 2 clocks after scan_go.
- Read port: rd_data/rd_valid reflect file[rd_chnl] on the next clock. A write and a read of the same channel in the same cycle returns the new value.
- Changing ch_mask mid-scan has no effect until the next scan start.

Optional Feature:
- Macro: A2D_SEQ_TIMEOUT_EN.
- When defined: a counter runs in WAIT. If it reaches TIMEOUT_CYC without a cnv_cmplt rising edge:
  - timeout_err is set (sticky; cleared only by reset or an accepted scan_go).
  - The channel is abandoned, its valid bit stays 0, and the FSM advances to NEXT.
- When undefined: WAIT blocks indefinitely and timeout_err is constant 0.

Test Plan:
- Reset mid-WAIT (assert rst_n=0 while busy) -> all outputs 0 next edge; no strt_cnv for 20 clocks after release with scan_go=0.
- ch_mask=8'h81, AVG_LOG2=2, ADC128S model returns analog 12'h400,12'h404,12'h408,12'h40C on ch0 -> exactly 8 strt_cnv pulses, chnnl=0 then 7; file[0]=12'h406; rd_valid=1 for rd_chnl=0 and 7, 0 for rd_chnl=3.
- ch_mask=8'h00, scan_go -> scan_done 2 clocks later, no strt_cnv, busy high for exactly 2 clocks.
- Full sweep: ch_mask=8'hFF, AVG_LOG2=0, analog 12'hFFF on every channel -> file[n]=12'hFFF for all 8 channels, channels visited 0..7 in order; spacing from cnv_cmplt rise to the next strt_cnv >= GAP_CYCLES clocks.
- cont=1, ch_mask=8'h04, scan_go once -> repeated scan_done pulses on ch2 only; deassert cont -> busy falls after the current scan; scan_go pulsed while busy is ignored.
- With A2D_SEQ_TIMEOUT_EN and TIMEOUT_CYC=50, MISO path of ch1 held so cnv_cmplt never rises, ch_mask=8'h03 -> timeout_err=1 ~50 clocks into ch1 WAIT; valid[0]=1, valid[1]=0; scan_done still pulses.

Source files
------------

// File: rtl/a2d_scan_seq_if.sv
// a2d_scan_seq_if: conversion handshake between the scan sequencer and A2D_intf.
// master = sequencer side (drives strt_cnv/chnnl), slave = A2D_intf side.
interface a2d_scan_seq_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_scan_seq.sv
// a2d_scan_seq: walks the enabled ADC128S channels through A2D_intf, averages
// 2^AVG_LOG2 conversions per channel and keeps one un-inverted 12-bit reading
// per channel behind a registered read port.
// Optional watchdog on the conversion wait: define A2D_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for scan_go
// NEXT  | pick lowest enabled channel at/above idx, or finish the scan
// START | one-cycle strt_cnv to A2D_intf
// WAIT  | waiting for cnv_cmplt rising edge
// GAP   | GAP_CYCLES idle clocks, then next sample or store the average
// DONE  | scan_done pulse; re-scan if cont, else back to IDLE
module a2d_scan_seq #(
  parameter int AVG_LOG2    = 2,
  parameter int GAP_CYCLES  = 10,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_go,
  input  logic                  cont,
  input  logic [7:0]            ch_mask,
  a2d_scan_seq_if.master        a2d,
  input  logic [2:0]            rd_chnl,
  output logic [11:0]           rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  scan_done,
  output logic                  timeout_err
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] SMP_TGT  = SMP_W'(1 << AVG_LOG2);
  localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NEXT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic [7:0]       mask_q;
  logic [3:0]       idx;
  logic [2:0]       chnnl_q;
  logic             strt_q;
  logic [ACC_W-1:0] acc;
  logic [SMP_W-1:0] smp_cnt;
  logic [7:0]       gap_cnt;
  logic             cnv_q;
  logic             cnv_rise;
  logic             go_acc;
  logic             wr_en;
  logic [11:0]      wr_val;
  logic             nxt_found;
  logic [2:0]       nxt_ch;
  logic             to_expired;
  logic [11:0]      file_q [8];
  logic [7:0]       valid_q;

  assign a2d.strt_cnv = strt_q;
  assign a2d.chnnl    = chnnl_q;

  // Edge detect makes both pulse and level completion handshakes work.
  assign cnv_rise = a2d.cnv_cmplt & ~cnv_q;
  assign go_acc   = (state == S_IDLE) && scan_go;
  assign wr_en    = (state == S_GAP) && (gap_cnt == 8'd0) && (smp_cnt == SMP_TGT);
  assign wr_val   = acc[ACC_W-1:AVG_LOG2];

  // Lowest enabled channel at or above idx (descending loop so the lowest wins).
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (4'(i) >= idx)) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
    end
  end

`ifdef A2D_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  assign to_expired = (state == S_WAIT) && !cnv_rise && (to_cnt == '0);

  // Watchdog down-counter over WAIT; sticky error until reset or a new scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_START)
        to_cnt <= TO_LOAD;
      else if ((state == S_WAIT) && (to_cnt != '0))
        to_cnt <= to_cnt - TO_W'(1);
      if (go_acc)
        timeout_err <= 1'b0;
      else if (to_expired)
        timeout_err <= 1'b1;
    end
  end
`else
  assign to_expired  = 1'b0;
  // TIMEOUT_CYC only matters with the watchdog built in.
  assign timeout_err = (TIMEOUT_CYC > 0) ? 1'b0 : 1'b0;
`endif

  // Scan sequencing, averaging and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mask_q    <= 8'd0;
      idx       <= 4'd0;
      chnnl_q   <= 3'd0;
      strt_q    <= 1'b0;
      acc       <= '0;
      smp_cnt   <= '0;
      gap_cnt   <= 8'd0;
      cnv_q     <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      strt_q    <= 1'b0;
      scan_done <= 1'b0;
      cnv_q     <= a2d.cnv_cmplt;
      case (state)
        S_IDLE: begin
          if (scan_go) begin
            mask_q <= ch_mask;
            idx    <= 4'd0;
            busy   <= 1'b1;
            state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (nxt_found) begin
            chnnl_q <= nxt_ch;
            idx     <= {1'b0, nxt_ch};
            acc     <= '0;
            smp_cnt <= '0;
            strt_q  <= 1'b1;
            state   <= S_START;
          end else begin
            scan_done <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (cnv_rise) begin
            acc     <= acc + ACC_W'(~a2d.res);
            smp_cnt <= smp_cnt + SMP_W'(1);
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else if (to_expired) begin
            idx   <= {1'b0, chnnl_q} + 4'd1;
            state <= S_NEXT;
          end
        end
        S_GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (smp_cnt != SMP_TGT) begin
            strt_q <= 1'b1;
            state  <= S_START;
          end else begin
            idx   <= {1'b0, chnnl_q} + 4'd1;
            state <= S_NEXT;
          end
        end
        S_DONE: begin
          if (cont) begin
            mask_q <= ch_mask;
            idx    <= 4'd0;
            state  <= S_NEXT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result file and valid bits; valid bits are cleared only by an accepted scan_go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) file_q[i] <= 12'd0;
      valid_q <= 8'd0;
    end else begin
      if (go_acc)
        valid_q <= 8'd0;
      else if (wr_en)
        valid_q[chnnl_q] <= 1'b1;
      if (wr_en)
        file_q[chnnl_q] <= wr_val;
    end
  end

  // Registered read port with write-through for a same-cycle write to rd_chnl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 12'd0;
      rd_valid <= 1'b0;
    end else if (wr_en && (chnnl_q == rd_chnl)) begin
      rd_data  <= wr_val;
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= file_q[rd_chnl];
      rd_valid <= go_acc ? 1'b0 : valid_q[rd_chnl];
    end
  end

endmodule

// File: tb/tb_a2d_scan_seq.sv
// tb_a2d_scan_seq: directed bench for a2d_scan_seq with two instances
// (AVG_LOG2=2 and AVG_LOG2=0) each driven by a small ADC128S/A2D_intf model.
module tb_a2d_scan_seq;

  localparam int GAP_CYC = 10;
  localparam int ADC_LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_go_a = 1'b0, scan_go_b = 1'b0;
  logic        cont = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [2:0]  rd_chnl_a = 3'd0, rd_chnl_b = 3'd0;
  logic [11:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, sd_a, sd_b, terr_a, terr_b;
  logic        hold_ch1 = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  a2d_scan_seq_if ifa ();
  a2d_scan_seq_if ifb ();

  a2d_scan_seq #(.AVG_LOG2(2), .GAP_CYCLES(GAP_CYC), .TIMEOUT_CYC(50)) dut_a (
    .clk(clk), .rst_n(rst_n), .scan_go(scan_go_a), .cont(cont), .ch_mask(ch_mask),
    .a2d(ifa), .rd_chnl(rd_chnl_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .scan_done(sd_a), .timeout_err(terr_a));

  a2d_scan_seq #(.AVG_LOG2(0), .GAP_CYCLES(GAP_CYC), .TIMEOUT_CYC(1023)) dut_b (
    .clk(clk), .rst_n(rst_n), .scan_go(scan_go_b), .cont(cont), .ch_mask(ch_mask),
    .a2d(ifb), .rd_chnl(rd_chnl_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .scan_done(sd_b), .timeout_err(terr_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] analog_a(input logic [2:0] ch, input int n);
    if (ch == 3'd0) return 12'h400 + 12'(4 * n);
    return 12'h123;
  endfunction

  // ADC model A: completion pulse ADC_LAT+1 clocks after strt_cnv, complemented data.
  logic       a_pend;
  int         a_lat;
  logic [2:0] a_ch;
  int         a_nsmp [8];
  int         a_strt;
  logic [2:0] a_chq [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pend <= 1'b0; a_lat <= 0; a_ch <= 3'd0; a_strt <= 0;
      ifa.cnv_cmplt <= 1'b0; ifa.res <= 12'h000;
      for (int i = 0; i < 8; i++) a_nsmp[i] <= 0;
      a_chq.delete();
    end else begin
      ifa.cnv_cmplt <= 1'b0;
      if (ifa.strt_cnv) begin
        a_pend <= 1'b1; a_lat <= ADC_LAT; a_ch <= ifa.chnnl; a_strt <= a_strt + 1;
        a_chq.push_back(ifa.chnnl);
      end else if (a_pend) begin
        if (a_lat == 0) begin
          a_pend <= 1'b0;
          if (!(hold_ch1 && a_ch == 3'd1)) begin
            ifa.cnv_cmplt <= 1'b1;
            ifa.res <= ~analog_a(a_ch, a_nsmp[a_ch]);
            a_nsmp[a_ch] <= a_nsmp[a_ch] + 1;
          end
        end else a_lat <= a_lat - 1;
      end
    end
  end

  // ADC model B: full-scale on every channel; tracks cnv_cmplt-to-strt_cnv spacing.
  logic       b_pend;
  int         b_lat;
  int         b_strt;
  int         b_rise;
  int         b_min_gap;
  logic [2:0] b_chq [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_pend <= 1'b0; b_lat <= 0; b_strt <= 0; b_rise <= -1; b_min_gap <= 1000000;
      ifb.cnv_cmplt <= 1'b0; ifb.res <= 12'h000;
      b_chq.delete();
    end else begin
      ifb.cnv_cmplt <= 1'b0;
      if (ifb.cnv_cmplt) b_rise <= cyc;
      if (ifb.strt_cnv) begin
        b_pend <= 1'b1; b_lat <= ADC_LAT; b_strt <= b_strt + 1;
        b_chq.push_back(ifb.chnnl);
        if (b_rise >= 0 && (cyc - b_rise) < b_min_gap) b_min_gap <= cyc - b_rise;
      end else if (b_pend) begin
        if (b_lat == 0) begin
          b_pend <= 1'b0;
          ifb.cnv_cmplt <= 1'b1;
          ifb.res <= ~12'hFFF;
        end else b_lat <= b_lat - 1;
      end
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int inst, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((inst == 0 && sd_a) || (inst == 1 && sd_b)) begin
        seen = 1'b1;
        break;
      end
    end
    chk_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic rd_a(input logic [2:0] ch, output logic [12:0] vd);
    rd_chnl_a = ch;
    @(negedge clk);
    vd = {rd_valid_a, rd_data_a};
  endtask

  task automatic rd_b(input logic [2:0] ch, output logic [12:0] vd);
    rd_chnl_b = ch;
    @(negedge clk);
    vd = {rd_valid_b, rd_data_b};
  endtask

  task automatic pulse_go(input int inst);
    if (inst == 0) scan_go_a = 1'b1; else scan_go_b = 1'b1;
    @(negedge clk);
    scan_go_a = 1'b0;
    scan_go_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [12:0] vd;
    logic [23:0] pk;
    logic [5:0]  trace;
    int          s0, q0;
    logic        seen;

    // Reset values.
    tick(3);
    chk_val("rst_outs_a", {ifa.strt_cnv, ifa.chnnl, busy_a, sd_a, rd_valid_a, rd_data_a, terr_a}, 32'd0);
    chk_val("rst_outs_b", {ifb.strt_cnv, ifb.chnnl, busy_b, sd_b, rd_valid_b, rd_data_b, terr_b}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Reset asserted mid-WAIT aborts the scan.
    ch_mask = 8'h81;
    pulse_go(0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ifa.strt_cnv) seen = 1'b1; else @(negedge clk);
    end
    chk_val("midrst_strt_seen", 32'(seen), 32'd1);
    tick(3);
    chk_val("midrst_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("midrst_outs", {ifa.strt_cnv, ifa.chnnl, busy_a, sd_a, rd_valid_a, rd_data_a, terr_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    chk_val("midrst_no_strt", 32'(a_strt), 32'd0);
    chk_val("midrst_busy_after", 32'(busy_a), 32'd0);

    // Mask 0x81 with 4-sample averaging.
    ch_mask = 8'h81;
    pulse_go(0);
    wait_done(0, 1000, "m81_done");
    chk_val("m81_nstrt", 32'(a_strt), 32'd8);
    pk = 24'd0;
    foreach (a_chq[i]) pk = {pk[20:0], a_chq[i]};
    chk_val("m81_order", 32'(pk), 32'(24'o00007777));
    @(negedge clk);
    chk_val("m81_busy_fall", 32'(busy_a), 32'd0);
    rd_a(3'd0, vd); chk_val("m81_rd0", 32'(vd), {19'd0, 1'b1, 12'h406});
    rd_a(3'd7, vd); chk_val("m81_rd7", 32'(vd), {19'd0, 1'b1, 12'h123});
    rd_a(3'd3, vd); chk_val("m81_rd3", 32'(vd), 32'd0);

    // Empty mask: done two clocks after scan_go, busy for exactly two clocks.
    s0 = a_strt;
    ch_mask = 8'h00;
    scan_go_a = 1'b1;
    @(negedge clk); scan_go_a = 1'b0; trace[5:4] = {busy_a, sd_a};
    @(negedge clk); trace[3:2] = {busy_a, sd_a};
    @(negedge clk); trace[1:0] = {busy_a, sd_a};
    chk_val("m00_busy_done", 32'(trace), 32'(6'b10_11_00));
    chk_val("m00_no_strt", 32'(a_strt), 32'(s0));
    rd_a(3'd0, vd); chk_val("m00_valid_clr", 32'(vd[12]), 32'd0);

    // Full sweep on the non-averaging instance.
    ch_mask = 8'hFF;
    pulse_go(1);
    wait_done(1, 1500, "sweep_done");
    chk_val("sweep_nstrt", 32'(b_strt), 32'd8);
    pk = 24'd0;
    foreach (b_chq[i]) pk = {pk[20:0], b_chq[i]};
    chk_val("sweep_order", 32'(pk), 32'(24'o01234567));
    chk_val("sweep_gap_ok", 32'(b_min_gap >= GAP_CYC), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd_b(3'(i), vd);
      chk_val($sformatf("sweep_rd%0d", i), 32'(vd), {19'd0, 1'b1, 12'hFFF});
    end

    // Continuous mode on channel 2; scan_go while busy is ignored.
    s0 = a_strt;
    q0 = a_chq.size();
    cont = 1'b1;
    ch_mask = 8'h04;
    pulse_go(0);
    wait_done(0, 400, "cont_done1");
    tick(3);
    pulse_go(0);
    tick(2);
    rd_a(3'd2, vd); chk_val("cont_go_ignored", 32'(vd), {19'd0, 1'b1, 12'h123});
    wait_done(0, 400, "cont_done2");
    wait_done(0, 400, "cont_done3");
    chk_val("cont_nstrt3", 32'(a_strt - s0), 32'd12);
    tick(10);
    cont = 1'b0;
    ch_mask = 8'h01;
    wait_done(0, 400, "cont_done4");
    @(negedge clk);
    chk_val("cont_busy_fall", 32'(busy_a), 32'd0);
    tick(40);
    chk_val("cont_nstrt_total", 32'(a_strt - s0), 32'd16);
    pk = 24'd0;
    for (int i = q0; i < a_chq.size(); i++) if (a_chq[i] != 3'd2) pk = pk + 24'd1;
    chk_val("cont_only_ch2", 32'(pk), 32'd0);

`ifdef A2D_SEQ_TIMEOUT_EN
    // Watchdog: ch1 never completes.
    hold_ch1 = 1'b1;
    ch_mask = 8'h03;
    pulse_go(0);
    wait_done(0, 600, "to_done");
    chk_val("to_err", 32'(terr_a), 32'd1);
    rd_a(3'd0, vd); chk_val("to_valid0", 32'(vd[12]), 32'd1);
    rd_a(3'd1, vd); chk_val("to_valid1", 32'(vd[12]), 32'd0);
    hold_ch1 = 1'b0;
    ch_mask = 8'h00;
    pulse_go(0);
    chk_val("to_err_clr", 32'(terr_a), 32'd0);
    tick(4);
`else
    chk_val("no_to_err", 32'({terr_a, terr_b}), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
